gemv_dot_accum: RTL and testbench

Streaming signed dot-product accumulator for the GEMV datapath. It sits directly downstream of the 64×64→64 signed multiplier and consumes one product per cycle over a valid/ready stream. It sums the products of one matrix row into a 64-bit wrap-around accumulator. When the row's last product is accepted, it emits the row result together with its row index to the write-back stage.

---
 rtl/gemv_pkg.sv | 13 +
 rtl/gemv_dot_accum_if.sv | 27 ++
 rtl/gemv_dot_accum.sv | 72 +++++++
 tb/tb_gemv_dot_accum.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gemv_pkg.sv
// Shared types and widths for the GEMV dot-product accumulator.
// Holds the datapath width, default row-counter width and FSM states.
package gemv_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ROW_W_DEF  = 16;

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/gemv_dot_accum_if.sv
// Product input stream and row-result output stream of the accumulator.
// Ports: in_prod/in_last/in_valid/in_ready, out_sum/out_row/out_valid/out_ready.
interface gemv_dot_accum_if
  import gemv_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int RW = ROW_W_DEF
);
  logic [DW-1:0] in_prod;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_sum;
  logic [RW-1:0] out_row;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_prod, in_last, in_valid, out_ready,
    input  in_ready, out_sum, out_row, out_valid
  );

  modport slave (
    input  in_prod, in_last, in_valid, out_ready,
    output in_ready, out_sum, out_row, out_valid
  );
endinterface

// File: rtl/gemv_dot_accum.sv
// Streaming signed dot-product accumulator: sums one row of products.
// Ports: ap_clk, ap_rst (async high), clear, s (stream slave), busy.
module gemv_dot_accum
  import gemv_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic clear,
  gemv_dot_accum_if.slave s,
  output logic busy
);

  acc_state_e              r_state;
  logic [DATA_WIDTH-1:0]   r_acc;
  logic [ROW_W-1:0]        r_row_cnt;
  logic [DATA_WIDTH-1:0]   r_out_sum;
  logic [ROW_W-1:0]        r_out_row;
  logic                    r_out_valid;

  logic                    w_in_ready;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic [DATA_WIDTH-1:0]   w_base;
  logic [DATA_WIDTH-1:0]   w_sum;

  // Ready never looks at in_valid, so no comb loop with the producer.
  assign w_in_ready = !clear && (!r_out_valid || s.out_ready);
  assign w_in_fire  = s.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && s.out_ready;

  // A row starts from zero in IDLE; wrap-around add is intended.
  assign w_base = (r_state == ACC_RUN) ? r_acc : '0;
  assign w_sum  = w_base + s.in_prod;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= ACC_IDLE;
      r_acc       <= '0;
      r_row_cnt   <= '0;
      r_out_sum   <= '0;
      r_out_row   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_out_fire)
        r_out_valid <= 1'b0;
      if (clear) begin
        r_state   <= ACC_IDLE;
        r_row_cnt <= '0;
      end else if (w_in_fire) begin
        if (s.in_last) begin
          r_out_sum   <= w_sum;
          r_out_row   <= r_row_cnt;
          r_out_valid <= 1'b1;
          r_row_cnt   <= r_row_cnt + 1'b1;
          r_state     <= ACC_IDLE;
        end else begin
          r_acc   <= w_sum;
          r_state <= ACC_RUN;
        end
      end
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_sum   = r_out_sum;
  assign s.out_row   = r_out_row;
  assign s.out_valid = r_out_valid;
  assign busy        = (r_state == ACC_RUN);

endmodule

// File: tb/tb_gemv_dot_accum.sv
// Randomized and directed bench for gemv_dot_accum.
// Reference model keeps each row's beats in a queue and sums them on last.
module tb_gemv_dot_accum;
  import gemv_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic clear  = 1'b0;
  logic busy;

  gemv_dot_accum_if bus ();

  gemv_dot_accum dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .clear  (clear),
    .s      (bus.slave),
    .busy   (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [63:0] m_beats[$];
  logic [15:0] m_row;
  logic        m_ov;
  logic [63:0] m_sum;
  logic [15:0] m_orow;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_row  = '0;
    m_ov   = 1'b0;
    m_sum  = '0;
    m_orow = '0;
  endtask

  function automatic logic [63:0] row_total();
    logic [63:0] t;
    t = '0;
    foreach (m_beats[i]) t = t + m_beats[i];
    return t;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, ".ov"},   {63'd0, bus.out_valid}, {63'd0, m_ov});
    chk({tag, ".sum"},  bus.out_sum, m_sum);
    chk({tag, ".row"},  {48'd0, bus.out_row}, {48'd0, m_orow});
    chk({tag, ".busy"}, {63'd0, busy}, {63'd0, m_beats.size() != 0});
  endtask

  // One clock cycle: drive at negedge, check ready, update model at
  // the edge, check registered outputs at the next negedge.
  task automatic cyc(input logic        v,
                     input logic [63:0] p,
                     input logic        l,
                     input logic        ordy,
                     input logic        cl);
    logic rdy, fire, ofire;
    bus.in_valid  = v;
    bus.in_prod   = p;
    bus.in_last   = l;
    bus.out_ready = ordy;
    clear         = cl;
    #1;
    rdy   = !cl && (!m_ov || ordy);
    fire  = v && rdy;
    ofire = m_ov && ordy;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
    @(posedge ap_clk);
    if (ofire) m_ov = 1'b0;
    if (cl) begin
      m_beats.delete();
      m_row = '0;
    end else if (fire) begin
      m_beats.push_back(p);
      if (l) begin
        m_sum  = row_total();
        m_orow = m_row;
        m_ov   = 1'b1;
        m_row  = m_row + 16'd1;
        m_beats.delete();
      end
    end
    @(negedge ap_clk);
    chk_outs("cyc");
  endtask

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    chk_outs("rst");
    chk("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Row {3,-5,7,10}
    cyc(1, 64'd3, 0, 1, 0);
    cyc(1, -64'sd5, 0, 1, 0);
    cyc(1, 64'd7, 0, 1, 0);
    chk("r4.ov_pre", {63'd0, bus.out_valid}, 64'd0);
    cyc(1, 64'd10, 1, 1, 0);
    chk("r4.sum", bus.out_sum, 64'd15);
    chk("r4.row", {48'd0, bus.out_row}, 64'd0);
    chk("r4.ov", {63'd0, bus.out_valid}, 64'd1);
    cyc(0, 0, 0, 1, 0);

    // Back-to-back single-element rows from row 0
    cyc(0, 0, 0, 1, 1);
    cyc(1, MAXP, 1, 1, 0);
    chk("single0.sum", bus.out_sum, MAXP);
    chk("single0.row", {48'd0, bus.out_row}, 64'd0);
    cyc(1, 64'd1, 1, 1, 0);
    chk("single1.sum", bus.out_sum, 64'd1);
    chk("single1.row", {48'd0, bus.out_row}, 64'd1);

    // Overflow wrap
    cyc(1, MAXP, 0, 1, 0);
    cyc(1, 64'd1, 1, 1, 0);
    chk("wrap.sum", bus.out_sum, 64'h8000_0000_0000_0000);
    chk("wrap.row", {48'd0, bus.out_row}, 64'd2);

    // Backpressure: stalled beats then resume
    cyc(1, 64'd5, 0, 0, 0);
    chk("bp.rdy", {63'd0, bus.in_ready}, 64'd0);
    cyc(1, 64'd5, 0, 0, 0);
    chk("bp.busy", {63'd0, busy}, 64'd0);
    cyc(1, 64'd5, 0, 1, 0);
    cyc(1, 64'd6, 1, 1, 0);
    chk("bp.sum", bus.out_sum, 64'd11);
    chk("bp.row", {48'd0, bus.out_row}, 64'd3);

    // Clear mid-row
    cyc(1, 64'd4, 0, 1, 0);
    cyc(1, 64'd4, 0, 1, 0);
    chk("clr.busy_pre", {63'd0, busy}, 64'd1);
    cyc(0, 0, 0, 1, 1);
    chk("clr.busy", {63'd0, busy}, 64'd0);
    cyc(1, 64'd9, 1, 1, 0);
    chk("clr.sum", bus.out_sum, 64'd9);
    chk("clr.row", {48'd0, bus.out_row}, 64'd0);

    // Async reset with a pending result and a partial row
    cyc(1, 64'd2, 0, 0, 0);
    #2;
    ap_rst = 1'b1;
    #1;
    model_reset();
    chk_outs("arst");
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    cyc(1, 64'd5, 1, 1, 0);
    chk("arst.row", {48'd0, bus.out_row}, 64'd0);
    chk("arst.sum", bus.out_sum, 64'd5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] p;
      p = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) p = MAXP;
      cyc($urandom_range(0, 3) != 0,
          p,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
